// File: rtl/brent_kung_pipe_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : brent_kung_pipe_adder_if
// Brief    : Operand/result handshake bundle for the pipelined Brent-Kung adder.
// Revision : 1.0 - initial release
// ============================================================================
interface brent_kung_pipe_adder_if #(
    parameter int WIDTH = 12
);
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] INPUTS;
    logic               cin;
    logic               sub;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH:0]     OUTS;
    logic               overflow;

    modport master (
        output in_valid, INPUTS, cin, sub, out_ready,
        input  in_ready, out_valid, OUTS, overflow
    );

    modport slave (
        input  in_valid, INPUTS, cin, sub, out_ready,
        output in_ready, out_valid, OUTS, overflow
    );
endinterface
`default_nettype wire

// File: rtl/brent_kung_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : brent_kung_pipe_adder
// Brief    : Parametrised Brent-Kung add/sub with STAGES register stages and
//            a globally stalled valid/ready pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module brent_kung_pipe_adder #(
    parameter int WIDTH  = 12,
    parameter int STAGES = 2,
    parameter int SUB_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    brent_kung_pipe_adder_if.slave  bus
);
    // Prefix positions: position 0 is the carry-in, position i+1 is operand bit i.
    localparam int c_npos   = WIDTH + 1;
    localparam int c_levels = $clog2(c_npos);
    localparam int c_nlev   = 2 * c_levels - 1;
    localparam logic [c_npos-1:0] c_one = {{(c_npos-1){1'b0}}, 1'b1};

    if (WIDTH < 2 || WIDTH > 64 || STAGES < 1 || STAGES > $clog2(WIDTH) + 2) begin : g_param_check
        $error("brent_kung_pipe_adder: illegal WIDTH/STAGES combination");
    end

    // One Brent-Kung level: levels 1..c_levels are up-sweep, the rest down-sweep.
    function automatic logic [2*c_npos-1:0] bk_level(
        input logic [c_npos-1:0] g,
        input logic [c_npos-1:0] p,
        input int                lvl
    );
        logic [c_npos-1:0] m;
        logic [c_npos-1:0] gs;
        logic [c_npos-1:0] ps;
        int                d;
        int                span;
        d    = (lvl <= c_levels) ? lvl - 1 : 2 * c_levels - 1 - lvl;
        span = 1 << d;
        m    = '0;
        for (int i = 0; i < c_npos; i++) begin
            if (lvl <= c_levels) begin
                if ((i + 1) % (2 * span) == 0) m = m | (c_one << i);
            end else if (((i + 1) % (2 * span) == span) && (i >= 2 * span)) begin
                m = m | (c_one << i);
            end
        end
        gs = g << span;
        ps = p << span;
        return {g | (m & p & gs), (p & ~m) | (m & p & ps)};
    endfunction

    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_sub_on;
    logic              w_c0;
    logic [c_npos-1:0] w_g0;
    logic [c_npos-1:0] w_p0;
    logic              w_advance;
    logic              r_out_valid;
    logic [WIDTH:0]    r_outs;
    logic              r_overflow;

    for (genvar i = 0; i < WIDTH; i++) begin : g_split
        assign w_a[i] = bus.INPUTS[2*i];
        assign w_b[i] = bus.INPUTS[2*i+1];
    end

    assign w_sub_on  = bus.sub & (SUB_EN != 0);
    assign w_b_eff   = w_b ^ {WIDTH{w_sub_on}};
    assign w_c0      = bus.cin ^ w_sub_on;
    assign w_g0      = {w_a & w_b_eff, w_c0};
    assign w_p0      = {w_a ^ w_b_eff, 1'b0};

    // Global stall: every stage shifts together whenever the output can move.
    assign w_advance    = bus.out_ready | ~r_out_valid;
    assign bus.in_ready = w_advance;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int c_lo = (c_nlev * s) / STAGES + 1;
        localparam int c_hi = (c_nlev * (s + 1)) / STAGES;

        logic [c_npos-1:0] w_in_g;
        logic [c_npos-1:0] w_in_p;
        logic [WIDTH-1:0]  w_in_x;
        logic              w_in_v;
        logic [c_npos-1:0] w_g;
        logic [c_npos-1:0] w_p;

        if (s == 0) begin : g_head
            assign w_in_g = w_g0;
            assign w_in_p = w_p0;
            assign w_in_x = w_a ^ w_b_eff;
            assign w_in_v = bus.in_valid;
        end else begin : g_link
            assign w_in_g = g_stage[s-1].g_reg.r_g;
            assign w_in_p = g_stage[s-1].g_reg.r_p;
            assign w_in_x = g_stage[s-1].g_reg.r_x;
            assign w_in_v = g_stage[s-1].g_reg.r_v;
        end

        always_comb begin
            logic [2*c_npos-1:0] t;
            t   = '0;
            w_g = w_in_g;
            w_p = w_in_p;
            for (int l = c_lo; l <= c_hi; l++) begin
                t   = bk_level(w_g, w_p, l);
                w_g = t[2*c_npos-1:c_npos];
                w_p = t[c_npos-1:0];
            end
        end

        if (s < STAGES - 1) begin : g_reg
            logic [c_npos-1:0] r_g;
            logic [c_npos-1:0] r_p;
            logic [WIDTH-1:0]  r_x;
            logic              r_v;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_g <= '0;
                    r_p <= '0;
                    r_x <= '0;
                    r_v <= 1'b0;
                end else if (w_advance) begin
                    r_g <= w_g;
                    r_p <= w_p;
                    r_x <= w_in_x;
                    r_v <= w_in_v;
                end
            end
        end else begin : g_out
            // After the full network w_g[j] is the carry into bit j.
            logic [WIDTH-1:0] w_sum;
            logic             unused_p;
            assign w_sum    = w_in_x ^ w_g[WIDTH-1:0];
            assign unused_p = ^w_p;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_outs      <= '0;
                    r_overflow  <= 1'b0;
                    r_out_valid <= 1'b0;
                end else if (w_advance) begin
                    r_outs      <= {w_g[WIDTH], w_sum};
                    r_overflow  <= w_g[WIDTH] ^ w_g[WIDTH-1];
                    r_out_valid <= w_in_v;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.OUTS      = r_outs;
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: doc/brent_kung_pipe_adder.md
Name: brent_kung_pipe_adder

Overview:
- Parametrised, pipelined successor to the combinational 12-bit Brent-Kung adder.
- Operand bits arrive interleaved on one INPUTS bus. The block adds, or subtracts, the two operands plus a carry/borrow-in through a Brent-Kung prefix network split into STAGES register stages.
- Results move through the pipeline under a valid/ready handshake with backpressure.
- Sits in the datapath playground as the drop-in, clocked adder that synthesis-flow experiments instantiate at arbitrary widths.

Parameters:
- WIDTH, 12, operand width in bits; legal range 2..64.
- STAGES, 2, number of pipeline register stages; this is the latency in cycles. Legal range 1..clog2(WIDTH)+2.
- SUB_EN, 1, if 1 the sub port is honoured; if 0 the sub port is ignored and the block always adds.

Ports:
- clk, input, 1, clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, INPUTS/cin/sub hold a new operation.
- in_ready, output, 1, block accepts an operation this cycle.
- INPUTS, input, 2*WIDTH, interleaved operands: INPUTS[2i]=a[i], INPUTS[2i+1]=b[i].
- cin, input, 1, carry-in (add) or borrow-in (sub).
- sub, input, 1, 1 = a - b - cin; 0 = a + b + cin.
- out_valid, output, 1, OUTS/overflow hold a completed result.
- out_ready, input, 1, consumer accepts the result this cycle.
- OUTS, output, WIDTH+1, bits [WIDTH-1:0] are the sum; bit [WIDTH] is carry-out.
- overflow, output, 1, two's-complement signed overflow of the result.

Behaviour:
- Reset, asynchronous, any time including mid-operation:
  - all stage valid bits clear;
  - out_valid=0, OUTS=0, overflow=0.
  - In-flight operations are discarded and not replayed.
  - in_ready=1 during and after reset.
- Arithmetic:
  - b_eff = b ^ {WIDTH{sub&SUB_EN}};
  - c0 = cin ^ (sub&SUB_EN);
  - {OUTS[WIDTH],OUTS[WIDTH-1:0]} = a + b_eff + c0, computed at WIDTH+1 bits.
  - In sub mode OUTS[WIDTH]=1 means no borrow.
  - overflow = carry into MSB XOR carry out of MSB.
- Network structure:
  - g_i=a_i&b_eff_i and p_i=a_i^b_eff_i form stage 0.
  - Brent-Kung up-sweep and down-sweep prefix levels follow, then sum = p ^ {carries,c0}.
  - Carry-in is folded in as generate bit -1.
  - Prefix levels are split across STAGES as evenly as possible; stage k registers the g/p/partial-carry state plus p_i and the valid bit.
  - The final register is the output register, so OUTS is registered with no output combinational path.
- Latency and throughput:
  - An operation accepted at edge N appears with out_valid=1 after edge N+STAGES-1. STAGES=1 means the result is visible the cycle after acceptance.
  - Throughput is one operation per cycle while out_ready=1.
- Handshake:
  - Acceptance happens on in_valid&in_ready.
  - advance = out_ready | ~out_valid; in_ready = advance. This is a global stall: every stage shifts together.
  - When advance=0, all stage registers hold and out_valid/OUTS/overflow stay stable until out_ready.
  - Bubbles (stages with valid=0) shift like data and are not collapsed.
  - in_valid=1 with in_ready=0: the operation is not taken; the source holds it.
- Simultaneous events:
  - Output handshake and input acceptance in the same cycle is legal and sustains full rate.
  - rst overrides everything.
- Boundary cases:
  - Results wrap modulo 2^WIDTH, with the carry reported in OUTS[WIDTH].
  - sub with SUB_EN=0 is treated as 0.
  - An illegal STAGES or WIDTH is a synthesis error, reported via a generate-time check.

Test Plan:
- WIDTH=12, STAGES=2: a=0xFFF, b=0x001, cin=0, sub=0 → OUTS=0x1000, overflow=0, out_valid 2 cycles after acceptance.
- a=0x7FF, b=0x001, sub=0 → OUTS=0x0800, overflow=1. Then sub=1, a=0x000, b=0x001, cin=0 → OUTS=0x0FFF (bit12=0, borrow), overflow=0.
- Back-to-back stream of 8 random operations, out_ready=1 → 8 results on 8 consecutive cycles, in order, each equal to the reference a±b±cin.
- out_ready held 0 for 3 cycles with the pipeline full → in_ready=0, OUTS stable; on release, results drain in order with no loss or duplication.
- rst pulsed mid-stream (asynchronously, between edges) → out_valid drops immediately, OUTS=0; the next accepted operation completes with the correct value after STAGES cycles.
- Parameter sweep WIDTH∈{2,12,33,64} × STAGES∈{1,max}, 1000 random operations each → all match the golden model, including the cin=1 with all-ones carry-chain case.
